mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port synchronous RAM between the CPU instruction-fetch port and the CPU data port. Arbitrates per cycle with data-priority and an anti-starvation counter, and supports a data-side lock for atomic read-modify-write sequences. Sits between cpu and a single-port ram instance in top, replacing the dual-port RAM split.

Parameters:
ADDR_W, 32, byte address width of both requesters and RAM.
STARVE_LIMIT, 4, consecutive denied ifetch cycles after which ifetch wins the next arbitration; legal range 1..15.

Ports:
sys_clk  in  1  clock, all state on rising edge.
sys_res  in  1  asynchronous active-low reset.
if_req  in  1  ifetch request; held with if_addr stable until if_gnt.
if_addr  in  ADDR_W  ifetch byte address.
if_gnt  out  1  combinational grant to ifetch in this cycle.
if_valid  out  1  registered; if_rdata valid; one cycle after if_gnt.
if_rdata  out  32  fetched word.
d_req  in  1  data request; held with d_* stable until d_gnt.
d_addr  in  ADDR_W  data byte address.
d_we  in  1  1 = write, 0 = read.
d_mask  in  4  byte-enable for writes; ignored on reads.
d_wdata  in  32  write data.
d_lock  in  1  while 1 with a granted data access, holds RAM for data side.
d_gnt  out  1  combinational grant to data.
d_valid  out  1  registered; read data or write acknowledge, one cycle after d_gnt.
d_rdata  out  32  read word; forced 0 on write acknowledge.
ram_addr  out  ADDR_W  RAM address, muxed from the granted requester.
ram_wdata  out  32  RAM write data.
ram_mask  out  4  RAM byte-enable.
ram_we  out  1  RAM write enable; 1 only when d_gnt & d_we.
ram_rdata  in  32  RAM read data, valid one cycle after address.

Behaviour:
- Reset (sys_res=0, async): if_gnt=0, d_gnt=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, ram_we=0, starve counter=0, FSM=ARB, owner register=NONE. Any in-flight access is discarded; no valid pulse is produced after reset release for it.
- At most one grant per cycle; if_gnt & d_gnt never both 1. Grant is combinational from req and state; ram_* driven from the granted requester in the same cycle; ram_* = 0 when no grant.
- Back-to-back grants allowed every cycle. Latency fixed at 1: grant in cycle N, valid plus data in cycle N+1, owner tracked in a 1-cycle owner/we register.
- FSM ARB: if both req, data wins unless starve_cnt == STARVE_LIMIT, in which case ifetch wins. Single requester always wins. If d_gnt & d_lock, go to DLOCK.
- FSM DLOCK: only data can be granted; if_gnt=0. Leave to ARB on the first cycle d_lock=0 (combinational in that cycle: normal ARB rules apply). Starve counter frozen in DLOCK.
- starve_cnt: in ARB, increment (saturate at STARVE_LIMIT) when if_req & !if_gnt; clear when if_gnt or !if_req.
- Write: ram_we=1 in grant cycle; d_valid=1 next cycle with d_rdata=0.
- if_rdata/d_rdata hold last value when corresponding valid=0.
- Reset asserted during DLOCK: returns to ARB, lock released.

Optional Feature:
MEM_ARB_PERF_EN: when defined, adds outputs perf_if_grants[31:0], perf_d_grants[31:0], perf_if_stall[31:0] (cycles with if_req & !if_gnt), all reset to 0 by sys_res, wrapping at 2^32. When undefined, these ports and counters do not exist; arbitration behaviour identical.

Test Plan:
- Reset: hold sys_res=0 with if_req=d_req=1 -> all grants/valids 0, ram_we=0; release -> first cycle d_gnt=1 (data priority).
- Ifetch alone: if_req, if_addr=0x100, RAM word 0xDEADBEEF -> if_gnt same cycle, if_valid=1 and if_rdata=0xDEADBEEF next cycle.
- Contention with STARVE_LIMIT=4: both req continuously -> d_gnt for 4 cycles, if_gnt on 5th, then counter cleared and pattern repeats (4 d, 1 if).
- Write ack: d_we=1, d_mask=4'b0011, d_addr=0x20, d_wdata=0x12345678 -> ram_we=1, ram_mask=0011 in grant cycle; d_valid=1, d_rdata=0 next cycle; readback gives low halfword 0x5678.
- Lock: d_lock=1 for 3 data accesses with if_req=1 throughout -> if_gnt=0 for all 3 cycles and starve counter unchanged; d_lock=0 -> ARB resumes.
- Reset mid-access: assert sys_res=0 in cycle after d_gnt -> d_valid stays 0, FSM in ARB after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the instruction-fetch port, the data port and
// the single-port RAM side.
// The slave modport is the arbiter's view. The master modport is the view of
// the CPU and RAM around it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [31:0]       if_rdata;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [3:0]        d_mask;
    logic [31:0]       d_wdata;
    logic              d_lock;
    logic              d_gnt;
    logic              d_valid;
    logic [31:0]       d_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_mask;
    logic              ram_we;
    logic [31:0]       ram_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_addr, d_we, d_mask, d_wdata, d_lock,
        input  ram_rdata,
        output if_gnt, if_valid, if_rdata,
        output d_gnt, d_valid, d_rdata,
        output ram_addr, ram_wdata, ram_mask, ram_we
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_addr, d_we, d_mask, d_wdata, d_lock,
        output ram_rdata,
        input  if_gnt, if_valid, if_rdata,
        input  d_gnt, d_valid, d_rdata,
        input  ram_addr, ram_wdata, ram_mask, ram_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between the CPU
// instruction-fetch port and the CPU data port.
// Arbitration rules:
//   - Data has priority over ifetch.
//   - An anti-starvation counter gives ifetch the grant once it has been
//     denied STARVE_LIMIT times in a row.
//   - A data-side lock (d_lock) keeps the RAM for data during atomic sequences.
// Grants are combinational. Valid and read data follow one cycle after the grant.
// Optional build macro MEM_ARB_PERF_EN adds three free-running 32-bit
// performance counters: grants per port and ifetch stall cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// ARB   | normal per-cycle arbitration, data first, starvation override
// DLOCK | data holds the RAM; ifetch blocked until d_lock drops
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              sys_clk,
    input  logic              sys_res,
    mem_arbiter_if.slave      bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_if_stall
`endif
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {ARB = 1'b0, DLOCK = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        if_gnt, d_gnt, arb_mode;
    logic        own_if_q, own_d_q, own_we_q;
    logic [31:0] if_hold_q, d_hold_q, d_word;

    // Grant decision, next state and starvation counter update.
    // Dropping d_lock while in DLOCK makes that same cycle a normal ARB cycle.
    always_comb begin
        if_gnt   = 1'b0;
        d_gnt    = 1'b0;
        state_d  = state_q;
        starve_d = starve_q;
        arb_mode = (state_q == ARB) || !bus.d_lock;
        if (sys_res) begin
            if (arb_mode) begin
                if (bus.d_req && bus.if_req) begin
                    if (starve_q == LIMIT) if_gnt = 1'b1;
                    else                   d_gnt  = 1'b1;
                end else begin
                    d_gnt  = bus.d_req;
                    if_gnt = bus.if_req;
                end
                state_d = (d_gnt && bus.d_lock) ? DLOCK : ARB;
                if (if_gnt || !bus.if_req)  starve_d = '0;
                else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
            end else begin
                d_gnt = bus.d_req;
            end
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.ram_addr  = if_gnt ? bus.if_addr : (d_gnt ? bus.d_addr : '0);
    assign bus.ram_wdata = d_gnt ? bus.d_wdata : '0;
    assign bus.ram_mask  = d_gnt ? bus.d_mask : '0;
    assign bus.ram_we    = d_gnt && bus.d_we;

    // FSM state, starvation counter and the one-cycle owner/we record of the
    // access in flight.
    always_ff @(posedge sys_clk or negedge sys_res) begin
        if (!sys_res) begin
            state_q  <= ARB;
            starve_q <= '0;
            own_if_q <= 1'b0;
            own_d_q  <= 1'b0;
            own_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            own_if_q <= if_gnt;
            own_d_q  <= d_gnt;
            own_we_q <= d_gnt && bus.d_we;
        end
    end

    // The RAM output is passed straight through in the valid cycle and
    // captured, so rdata holds its last value when valid is low.
    // A write acknowledge returns zero.
    assign d_word = own_we_q ? '0 : bus.ram_rdata;

    // Capture the last delivered word of each port.
    always_ff @(posedge sys_clk or negedge sys_res) begin
        if (!sys_res) begin
            if_hold_q <= '0;
            d_hold_q  <= '0;
        end else begin
            if (own_if_q) if_hold_q <= bus.ram_rdata;
            if (own_d_q)  d_hold_q  <= d_word;
        end
    end

    assign bus.if_valid = own_if_q;
    assign bus.d_valid  = own_d_q;
    assign bus.if_rdata = own_if_q ? bus.ram_rdata : if_hold_q;
    assign bus.d_rdata  = own_d_q ? d_word : d_hold_q;

`ifdef MEM_ARB_PERF_EN
    // Grant and ifetch-stall event counters; they wrap naturally.
    always_ff @(posedge sys_clk or negedge sys_res) begin
        if (!sys_res) begin
            perf_if_grants <= '0;
            perf_d_grants  <= '0;
            perf_if_stall  <= '0;
        end else begin
            if (if_gnt)                  perf_if_grants <= perf_if_grants + 32'd1;
            if (d_gnt)                   perf_d_grants  <= perf_d_grants + 32'd1;
            if (bus.if_req && !if_gnt)   perf_if_stall  <= perf_if_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter.
// Structure:
//   - A word-level RAM model drives ram_rdata.
//   - A reference model decides from the arbitration rules which port must
//     own each cycle. It keeps its own copy of memory contents to predict
//     read data one cycle later.
//   - Directed sequences pin the model with literal expectations.
//   - A randomized phase follows the directed sequences.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LIMIT  = 4;

    logic sys_clk = 1'b0;
    logic sys_res = 1'b0;

    mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_grants, perf_d_grants, perf_if_stall;
`endif

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .sys_clk (sys_clk),
        .sys_res (sys_res),
        .bus     (bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_grants (perf_if_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_if_stall  (perf_if_stall)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'hDEADBEEF;      // byte address 0x100
        if (i == 8)  return 32'hAABBCCDD;      // byte address 0x20
        return (32'(i) * 32'h0001_0203) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // RAM model: read-first, registered output.
    logic [31:0] ram_mem [256];
    bit          ram_init = 1'b0;
    always @(posedge sys_clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (bus.ram_we) begin
            ram_mem[bus.ram_addr[9:2]] <= merge(ram_mem[bus.ram_addr[9:2]], bus.ram_wdata, bus.ram_mask);
        end
        bus.ram_rdata <= ram_mem[bus.ram_addr[9:2]];
    end

    // Reference model state.
    logic [31:0] shadow [256];
    bit          m_init = 1'b0;
    bit          m_locked;
    int          m_starve;
    bit          p_if, p_d;
    logic [31:0] p_if_data, p_d_data, h_if, h_d;
    bit          arb, eg_if, eg_d;
    logic [31:0] exp_addr;

    // Compare process: every cycle, mid-clock, against the model.
    always @(negedge sys_clk) begin
        if (!m_init) begin
            for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
            m_init = 1'b1;
        end
        if (!sys_res) begin
            m_locked = 1'b0; m_starve = 0; p_if = 1'b0; p_d = 1'b0;
            h_if = '0; h_d = '0;
            chk1("rst_if_gnt", bus.if_gnt, 1'b0);
            chk1("rst_d_gnt", bus.d_gnt, 1'b0);
            chk1("rst_if_valid", bus.if_valid, 1'b0);
            chk1("rst_d_valid", bus.d_valid, 1'b0);
            chk1("rst_ram_we", bus.ram_we, 1'b0);
            chk32("rst_if_rdata", bus.if_rdata, 32'h0);
            chk32("rst_d_rdata", bus.d_rdata, 32'h0);
        end else begin
            arb  = !m_locked || !bus.d_lock;
            eg_if = 1'b0;
            eg_d  = 1'b0;
            if (!arb)                          eg_d = bus.d_req;
            else if (bus.if_req && bus.d_req) begin
                if (m_starve >= LIMIT) eg_if = 1'b1;
                else                   eg_d  = 1'b1;
            end else begin
                eg_if = bus.if_req;
                eg_d  = bus.d_req;
            end
            exp_addr = eg_if ? bus.if_addr : (eg_d ? bus.d_addr : 32'h0);

            chk1("if_gnt", bus.if_gnt, eg_if);
            chk1("d_gnt", bus.d_gnt, eg_d);
            chk1("ram_we", bus.ram_we, eg_d && bus.d_we);
            chk32("ram_addr", bus.ram_addr, exp_addr);
            chk32("ram_wdata", bus.ram_wdata, eg_d ? bus.d_wdata : 32'h0);
            chk32("ram_mask", {28'h0, bus.ram_mask}, {28'h0, eg_d ? bus.d_mask : 4'h0});
            chk1("if_valid", bus.if_valid, p_if);
            chk1("d_valid", bus.d_valid, p_d);
            chk32("if_rdata", bus.if_rdata, p_if ? p_if_data : h_if);
            chk32("d_rdata", bus.d_rdata, p_d ? p_d_data : h_d);

            if (p_if) h_if = p_if_data;
            if (p_d)  h_d  = p_d_data;
            p_if = eg_if;
            p_d  = eg_d;
            if (eg_if) p_if_data = shadow[bus.if_addr[9:2]];
            if (eg_d) begin
                p_d_data = bus.d_we ? 32'h0 : shadow[bus.d_addr[9:2]];
                if (bus.d_we)
                    shadow[bus.d_addr[9:2]] = merge(shadow[bus.d_addr[9:2]], bus.d_wdata, bus.d_mask);
            end
            if (arb) begin
                if (eg_if || !bus.if_req)  m_starve = 0;
                else if (m_starve < LIMIT) m_starve = m_starve + 1;
                m_locked = eg_d && bus.d_lock;
            end
        end
    end

    task automatic next_cycle();
        @(posedge sys_clk);
        #1;
    endtask

    bit gi, gd;

    initial begin
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_addr = 32'h40; bus.d_we = 1'b0;
        bus.d_mask = 4'h0; bus.d_wdata = 32'h0; bus.d_lock = 1'b0;

        // Reset held with both requesting, then release: data wins first.
        repeat (3) @(negedge sys_clk);
        next_cycle();
        sys_res = 1'b1;
        @(negedge sys_clk);
        chk1("rel_d_gnt", bus.d_gnt, 1'b1);
        chk1("rel_if_gnt", bus.if_gnt, 1'b0);

        // Ifetch alone at 0x100.
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge sys_clk);
        chk1("ifa_gnt", bus.if_gnt, 1'b1);
        next_cycle();
        bus.if_req = 1'b0;
        @(negedge sys_clk);
        chk1("ifa_valid", bus.if_valid, 1'b1);
        chk32("ifa_rdata", bus.if_rdata, 32'hDEADBEEF);

        // Continuous contention: 4 data grants, then 1 ifetch, repeating.
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        bus.d_req = 1'b1; bus.d_addr = 32'h48;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            chk1("cont_d_gnt", bus.d_gnt, (k % 5) != 4);
            chk1("cont_if_gnt", bus.if_gnt, (k % 5) == 4);
            next_cycle();
            bus.d_addr = bus.d_addr + 32'h4;
        end

        // Masked write, acknowledge, readback.
        bus.if_req = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_mask = 4'b0011;
        bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
        @(negedge sys_clk);
        chk1("wr_ram_we", bus.ram_we, 1'b1);
        chk32("wr_ram_mask", {28'h0, bus.ram_mask}, 32'h3);
        chk32("wr_ram_addr", bus.ram_addr, 32'h20);
        next_cycle();
        bus.d_we = 1'b0; bus.d_mask = 4'h0;
        @(negedge sys_clk);
        chk1("wr_ack_valid", bus.d_valid, 1'b1);
        chk32("wr_ack_rdata", bus.d_rdata, 32'h0);
        next_cycle();
        bus.d_req = 1'b0;
        @(negedge sys_clk);
        chk1("rb_valid", bus.d_valid, 1'b1);
        chk32("rb_rdata", bus.d_rdata, 32'hAABB5678);

        // Lock for 3 accesses with ifetch waiting.
        // After the lock drops, ifetch must wait exactly 3 more data grants,
        // because the starvation counter stays frozen during DLOCK.
        next_cycle();
        bus.if_req = 1'b1; bus.if_addr = 32'h108;
        bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 32'h50;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            chk1("lock_if_gnt", bus.if_gnt, 1'b0);
            chk1("lock_d_gnt", bus.d_gnt, 1'b1);
            next_cycle();
            bus.d_addr = bus.d_addr + 32'h4;
        end
        bus.d_lock = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            chk1("unlock_d_gnt", bus.d_gnt, k < 3);
            chk1("unlock_if_gnt", bus.if_gnt, k == 3);
            next_cycle();
            bus.d_addr = bus.d_addr + 32'h4;
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;

        // Reset right after a locked data grant.
        // The access is dropped and arbitration comes back in ARB.
        @(negedge sys_clk);
        next_cycle();
        bus.d_req = 1'b1; bus.d_lock = 1'b1; bus.d_addr = 32'h60;
        @(negedge sys_clk);
        chk1("mid_d_gnt", bus.d_gnt, 1'b1);
        next_cycle();
        sys_res = 1'b0;
        bus.d_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h10C;
        @(negedge sys_clk);
        chk1("mid_rst_d_valid", bus.d_valid, 1'b0);
        next_cycle();
        sys_res = 1'b1;
        @(negedge sys_clk);
        chk1("mid_rel_d_valid", bus.d_valid, 1'b0);
        chk1("mid_rel_if_gnt", bus.if_gnt, 1'b1);
        next_cycle();
        bus.if_req = 1'b0; bus.d_lock = 1'b0;

        // Randomized traffic; requests are held until granted.
        for (int c = 0; c < 4000; c++) begin
            @(negedge sys_clk);
            gi = bus.if_gnt;
            gd = bus.d_gnt;
            next_cycle();
            if (!bus.if_req || gi) begin
                bus.if_req  = ($urandom_range(0, 3) != 0);
                bus.if_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!bus.d_req || gd) begin
                bus.d_req   = ($urandom_range(0, 3) != 0);
                bus.d_addr  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
                bus.d_we    = ($urandom_range(0, 2) == 0);
                bus.d_mask  = 4'($urandom_range(0, 15));
                bus.d_wdata = $urandom;
                bus.d_lock  = ($urandom_range(0, 4) == 0);
            end
        end

        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_lock = 1'b0;
        repeat (3) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
